prbs31_checker: RTL and testbench

// Byte-wide PRBS31 receiver/checker: consumes the 8-bit PRBS31 stream produced by the PRBS31 generator
// (or returned through a loopback path) and self-synchronises to it. After lock it counts bit errors.

---
 rtl/prbs31_checker.sv | 185 ++++++++++++++++++
 tb/tb_prbs31_checker.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_checker.sv
`default_nettype none
// ============================================================================
//  Module      : prbs31_checker
//  Description : Byte-wide PRBS31 (x^31 + x^28 + 1) receiver/checker.
//                Seeds from the incoming stream, hunts for a run of
//                error-free bytes, then locks and counts bit errors with
//                a free-running local reference.
//  Ports       : clk           clock, rising edge
//                rst_n         asynchronous active-low reset
//                i_rx_data     received byte, bit 7 first in time
//                i_rx_valid    byte strobe
//                i_err_clr     synchronous clear of the error total
//                o_locked      1 while in LOCKED
//                o_err_pulse   1-cycle pulse for an errored byte in LOCKED
//                o_err_bits    bit errors of the last byte checked in LOCKED
//                o_err_cnt     saturating bit-error total
//                o_fsm_state   0=SEED 1=HUNT 2=LOCKED
//  Revision    : 1.0  initial release
// ============================================================================
module prbs31_checker #(
   parameter int LOCK_BYTES   = 16,
   parameter int UNLOCK_BYTES = 4,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_valid,
   input  logic             i_err_clr,
   output logic             o_locked,
   output logic             o_err_pulse,
   output logic [3:0]       o_err_bits,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic [1:0]       o_fsm_state
);

   localparam logic [1:0] c_ST_SEED      = 2'd0;
   localparam logic [1:0] c_ST_HUNT      = 2'd1;
   localparam logic [1:0] c_ST_LOCKED    = 2'd2;
   localparam logic [7:0] c_LOCK_BYTES   = 8'(LOCK_BYTES);
   localparam logic [3:0] c_UNLOCK_BYTES = 4'(UNLOCK_BYTES);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [30:0]      r_s;
   logic [1:0]       r_seed_cnt;
   logic [7:0]       r_clean;
   logic [3:0]       r_bad;
   logic             r_err_pulse;
   logic [3:0]       r_err_bits;
   logic [CNT_W-1:0] r_err_cnt;

   logic [7:0]       w_pred;
   logic [7:0]       w_diff;
   logic [3:0]       w_e;
   logic [30:0]      w_s_rx;
   logic [30:0]      w_s_lock;
   logic [CNT_W:0]   w_sum;
   logic [CNT_W-1:0] w_cnt_sat;
   logic             w_locked;

   // Eight serial steps only ever look back to taps s[30-k] and s[27-k]
   // with k <= 7, so every predicted bit of a byte comes straight from the
   // current state regardless of which bits get shifted in.
   assign w_pred   = r_s[30:23] ^ r_s[27:20];
   assign w_s_rx   = {r_s[22:0], i_rx_data};
   assign w_s_lock = {r_s[22:0], w_pred};
   assign w_diff   = w_pred ^ i_rx_data;

   always_comb begin
      w_e = 4'd0;
      for (int i = 0; i < 8; i++) begin
         w_e = w_e + {3'b000, w_diff[i]};
      end
   end

   // One extra bit of headroom catches overflow for saturation.
   assign w_sum     = {1'b0, r_err_cnt} + (CNT_W+1)'(w_e);
   assign w_cnt_sat = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_SEED;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_rx_valid) begin
         case (r_state)
            c_ST_SEED: begin
               // An all-zero seed would lock the LFSR up; reseed instead.
               if (r_seed_cnt == 2'd3 && w_s_rx != 31'd0) begin
                  w_state_nxt = c_ST_HUNT;
               end
            end
            c_ST_HUNT: begin
               if (w_e == 4'd0 && (r_clean + 8'd1) == c_LOCK_BYTES) begin
                  w_state_nxt = c_ST_LOCKED;
               end
            end
            c_ST_LOCKED: begin
               if (w_e != 4'd0 && (r_bad + 4'd1) == c_UNLOCK_BYTES) begin
                  w_state_nxt = c_ST_SEED;
               end
            end
            default: w_state_nxt = c_ST_SEED;
         endcase
      end
   end

   always_comb begin
      w_locked = (r_state == c_ST_LOCKED);
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s         <= '0;
         r_seed_cnt  <= '0;
         r_clean     <= '0;
         r_bad       <= '0;
         r_err_pulse <= 1'b0;
         r_err_bits  <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_err_pulse <= 1'b0;
         if (i_rx_valid) begin
            case (r_state)
               c_ST_SEED: begin
                  // 2-bit counter wraps to 0 after the 4th byte either way.
                  r_s        <= w_s_rx;
                  r_seed_cnt <= r_seed_cnt + 2'd1;
                  r_clean    <= '0;
               end
               c_ST_HUNT: begin
                  // Self-synchronising: follow the received bits.
                  r_s <= w_s_rx;
                  if (w_e != 4'd0 || w_state_nxt == c_ST_LOCKED) begin
                     r_clean <= '0;
                  end else begin
                     r_clean <= r_clean + 8'd1;
                  end
                  if (w_state_nxt == c_ST_LOCKED) begin
                     r_bad <= '0;
                  end
               end
               c_ST_LOCKED: begin
                  // Free-run on predicted bits so a line error is not fed
                  // back into the taps and counted again.
                  r_s         <= w_s_lock;
                  r_err_bits  <= w_e;
                  r_err_pulse <= (w_e != 4'd0);
                  r_err_cnt   <= w_cnt_sat;
                  if (w_e == 4'd0 || w_state_nxt == c_ST_SEED) begin
                     r_bad <= '0;
                  end else begin
                     r_bad <= r_bad + 4'd1;
                  end
                  if (w_state_nxt == c_ST_SEED) begin
                     r_seed_cnt <= '0;
                  end
               end
               default: begin
                  r_seed_cnt <= '0;
               end
            endcase
         end
         if (i_err_clr) begin
            r_err_cnt <= '0;
         end
      end
   end

   assign o_locked    = w_locked;
   assign o_err_pulse = r_err_pulse;
   assign o_err_bits  = r_err_bits;
   assign o_err_cnt   = r_err_cnt;
   assign o_fsm_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_prbs31_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs31_checker
//  Description : Self-checking bench for prbs31_checker. A bit-serial
//                PRBS31 source and a bit-history reference model drive the
//                expectations; a second instance with a 4-bit counter
//                exercises saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prbs31_checker;

   localparam int LOCK_BYTES   = 16;
   localparam int UNLOCK_BYTES = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        err_clr = 1'b0;

   logic        locked, err_pulse;
   logic [3:0]  err_bits;
   logic [15:0] err_cnt;
   logic [1:0]  fsm_state;
   logic        locked_n, err_pulse_n;
   logic [3:0]  err_bits_n;
   logic [3:0]  err_cnt_n;
   logic [1:0]  fsm_state_n;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   prbs31_checker #(.LOCK_BYTES(LOCK_BYTES), .UNLOCK_BYTES(UNLOCK_BYTES), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .i_err_clr(err_clr), .o_locked(locked), .o_err_pulse(err_pulse),
      .o_err_bits(err_bits), .o_err_cnt(err_cnt), .o_fsm_state(fsm_state));

   prbs31_checker #(.LOCK_BYTES(LOCK_BYTES), .UNLOCK_BYTES(UNLOCK_BYTES), .CNT_W(4)) u_dut_n (
      .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .i_err_clr(err_clr), .o_locked(locked_n), .o_err_pulse(err_pulse_n),
      .o_err_bits(err_bits_n), .o_err_cnt(err_cnt_n), .o_fsm_state(fsm_state_n));

   // ------------------------------------------------ PRBS31 bit source
   // g holds the last 31 generated bits, g[0] oldest: b[n] = b[n-31]^b[n-28]
   bit g[$];

   task automatic gen_byte(output logic [7:0] b);
      bit nb;
      for (int i = 7; i >= 0; i--) begin
         nb = g[0] ^ g[3];
         b[i] = nb;
         g.push_back(nb);
         void'(g.pop_front());
      end
   endtask

   // ------------------------------------------------ reference model
   // h holds the 31 most recent bits of the checker's reference history.
   bit h[$];
   int m_mode, m_seedn, m_clean, m_bad, m_bits, m_pulse, m_cnt_w, m_cnt_n;

   task automatic hpush(input bit b);
      h.push_back(b);
      void'(h.pop_front());
   endtask

   task automatic model_reset();
      h = {};
      for (int i = 0; i < 31; i++) h.push_back(1'b0);
      m_mode = 0; m_seedn = 0; m_clean = 0; m_bad = 0;
      m_bits = 0; m_pulse = 0; m_cnt_w = 0; m_cnt_n = 0;
   endtask

   task automatic model_step(input logic v, input logic [7:0] d, input logic clr);
      int e;
      bit p;
      bit nz;
      m_pulse = 0;
      if (v) begin
         if (m_mode == 0) begin
            for (int i = 7; i >= 0; i--) hpush(d[i]);
            m_seedn++;
            if (m_seedn == 4) begin
               m_seedn = 0;
               nz = 0;
               foreach (h[k]) if (h[k]) nz = 1;
               if (nz) begin
                  m_mode = 1;
                  m_clean = 0;
               end
            end
         end else begin
            e = 0;
            for (int i = 7; i >= 0; i--) begin
               p = h[0] ^ h[3];
               if (p != d[i]) e++;
               hpush((m_mode == 1) ? bit'(d[i]) : p);
            end
            if (m_mode == 1) begin
               m_clean = (e == 0) ? m_clean + 1 : 0;
               if (m_clean == LOCK_BYTES) begin
                  m_mode = 2;
                  m_bad = 0;
               end
            end else begin
               m_bits  = e;
               m_pulse = (e != 0);
               m_cnt_w = (m_cnt_w + e > 65535) ? 65535 : m_cnt_w + e;
               m_cnt_n = (m_cnt_n + e > 15) ? 15 : m_cnt_n + e;
               m_bad   = (e != 0) ? m_bad + 1 : 0;
               if (m_bad == UNLOCK_BYTES) begin
                  m_mode = 0;
                  m_seedn = 0;
               end
            end
         end
      end
      if (clr) begin
         m_cnt_w = 0;
         m_cnt_n = 0;
      end
   endtask

   // ------------------------------------------------ checking helpers
   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("locked",    int'(locked),    int'(m_mode == 2));
      chk("fsm_state", int'(fsm_state), m_mode);
      chk("err_pulse", int'(err_pulse), m_pulse);
      chk("err_bits",  int'(err_bits),  m_bits);
      chk("err_cnt",   int'(err_cnt),   m_cnt_w);
      chk("err_cnt_n", int'(err_cnt_n), m_cnt_n);
   endtask

   task automatic cycle(input logic v, input logic [7:0] d, input logic clr);
      rx_valid = v;
      rx_data  = d;
      err_clr  = clr;
      @(posedge clk);
      model_step(v, d, clr);
      #1;
      check_all();
   endtask

   task automatic send(input logic [7:0] mask, input logic clr);
      logic [7:0] b;
      gen_byte(b);
      cycle(1'b1, b ^ mask, clr);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rx_valid = 1'b0;
      err_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int vcount;
      logic v;
      logic [7:0] b;

      g = {};
      for (int i = 0; i < 31; i++) g.push_back(bit'($urandom_range(0, 1)));
      g[0] = 1'b1;

      // reset state
      do_reset();
      chk("rst_locked", int'(locked), 0);
      chk("rst_cnt", int'(err_cnt), 0);

      // clean stream: 4 seed + 16 hunt bytes to lock
      for (int k = 1; k <= 20; k++) begin
         send(8'h00, 1'b0);
         if (k == 19) chk("t1_not_yet_locked", int'(locked), 0);
         if (k == 20) chk("t1_locked_at_20", int'(locked), 1);
      end
      chk("t1_cnt_zero", int'(err_cnt), 0);

      // single flipped bit counted exactly once
      send(8'h08, 1'b0);
      chk("t2_pulse", int'(err_pulse), 1);
      chk("t2_bits", int'(err_bits), 1);
      chk("t2_cnt", int'(err_cnt), 1);
      repeat (3) send(8'h00, 1'b0);
      chk("t2_no_repeat", int'(err_cnt), 1);
      chk("t2_pulse_gone", int'(err_pulse), 0);

      // clear on a clean byte
      send(8'h00, 1'b1);
      chk("clr_cnt", int'(err_cnt), 0);

      // four fully inverted bytes: 32 errors, unlock on the 4th
      for (int k = 1; k <= 4; k++) begin
         send(8'hFF, 1'b0);
         if (k == 3) chk("t3_still_locked", int'(locked), 1);
      end
      chk("t3_unlocked", int'(locked), 0);
      chk("t3_cnt32", int'(err_cnt), 32);
      chk("t5_cnt_sat", int'(err_cnt_n), 15);
      for (int k = 1; k <= 20; k++) begin
         send(8'h00, 1'b0);
         if (k == 19) chk("t3_relock_pre", int'(locked), 0);
         if (k == 20) chk("t3_relock", int'(locked), 1);
      end
      chk("t3_cnt_held", int'(err_cnt), 32);

      // err_clr coinciding with an errored byte
      send(8'h0F, 1'b1);
      chk("t5_clr_wins", int'(err_cnt), 0);
      chk("t5_clr_bits", int'(err_bits), 4);
      chk("t5_clr_pulse", int'(err_pulse), 1);

      // randomized traffic: gaps, sparse errors, occasional clears
      for (int k = 0; k < 400; k++) begin
         v = ($urandom_range(0, 3) != 0);
         if (v) begin
            gen_byte(b);
            b = b ^ (($urandom_range(0, 11) == 0) ? 8'($urandom) : 8'h00);
            cycle(1'b1, b, ($urandom_range(0, 49) == 0));
         end else begin
            cycle(1'b0, 8'($urandom), ($urandom_range(0, 49) == 0));
         end
      end

      // all-zero input never leaves SEED
      do_reset();
      for (int k = 0; k < 40; k++) begin
         cycle(1'b1, 8'h00, 1'b0);
         if (k % 8 == 7) chk("t4_in_seed", int'(fsm_state), 0);
      end
      chk("t4_not_locked", int'(locked), 0);

      // random gaps on a clean stream: lock after the 20th valid byte
      do_reset();
      vcount = 0;
      for (int it = 0; it < 400 && vcount < 20; it++) begin
         v = ($urandom_range(0, 1) != 0);
         if (v) begin
            send(8'h00, 1'b0);
            vcount++;
            if (vcount == 19) chk("t6_pre_lock", int'(locked), 0);
            if (vcount == 20) chk("t6_lock", int'(locked), 1);
         end else begin
            cycle(1'b0, 8'($urandom), 1'b0);
         end
      end
      chk("t6_reached_20", vcount, 20);
      send(8'hFF, 1'b0);
      chk("t6_err_before_rst", int'(err_bits), 8);

      // asynchronous reset while locked, sampled before any clock edge
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_locked", int'(locked), 0);
      chk("arst_state", int'(fsm_state), 0);
      chk("arst_pulse", int'(err_pulse), 0);
      chk("arst_bits", int'(err_bits), 0);
      chk("arst_cnt", int'(err_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) cycle(1'b0, 8'h00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
